rle_encoder: RTL and testbench
==============================

// Module: rle_encoder
// PURPOSE
//  Run-length encoder between the logic-analyzer sample path and the capture memory.
//  - Disabled: samples pass through unchanged.
//  - Enabled and armed: each new value is written once, followed by a flagged repeat-count word.
//  - One clock domain. No back-pressure: sti is always accepted, sto is valid-only.
// PARAMETERS
//  DW  32     sample/output word width in bits (encoding tables require DW=32)
//  KW  DW/8   number of byte groups
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     reset; synchronous, active-high
//  enable          in   1     1 = RLE encoding on, 0 = bypass
//  arm             in   1     encoding is active only when enable && arm
//  rle_mode        in   2     bit0: re-emit the value word after a saturated count; bit1 reserved (ignored)
//  disabledGroups  in   KW    byte-group disable mask; selects the sample width W
//  sti_data        in   DW    input sample
//  sti_valid       in   1     input sample qualifier
//  sto_data        out  DW    output word
//  sto_valid       out  1     output qualifier; one word per cycle
// BEHAVIOUR
//  - Reset: sto_valid=0, sto_data=0, FIFO empty, run state IDLE, count=0.
//  - Width decode from disabledGroups:
//      1110 -> W=8;  1100 -> W=16;  1000 -> W=24;  any other value -> W=32.
//      F = flag bit = W-1; MAXC = 2^(W-1)-1.
//  - Word formats:
//      VALUE = sti_data[W-2:0], with bit F=0 and bits above F = 0.
//      COUNT = repeat count in bits [W-2:0], with bit F=1 and bits above F = 0.
//  - Bypass (!(enable&&arm)): each valid sample is pushed unmodified (all DW bits).
//  - Active encoding (enable&&arm). Compare = equality of the sample's W-1 value bits.
//      IDLE, valid sample:        push VALUE; last=sample; count=0; go to RUN.
//      RUN, equal sample:         count++, nothing pushed.
//        If count reaches MAXC:   push COUNT(MAXC); count=0;
//                                 if rle_mode[0], also push VALUE(last).
//      RUN, different sample:     if count>0, push COUNT(count) first;
//                                 then push VALUE(new); last=new; count=0.
//      sti_valid=0:               no state change.
//  - Leaving active (enable or arm falls):
//      if count>0, push COUNT(count) that cycle; go to IDLE.
//      A bypass sample in that same cycle is pushed after the COUNT word.
//  - Entering active: state is IDLE, so the first sample is emitted as VALUE.
//  - Output FIFO:
//      depth 4; 0-2 pushes per cycle, in order; at most one pop per cycle (sto_* registered).
//      Latency: a sample pushed in cycle N appears on sto in cycle N+1 when the FIFO is empty.
//      sto_valid=0 when the FIFO is empty; sto_data holds its last value.
//      Overflow cannot occur: every 2-word push is preceded by a silent repeat cycle.
//      If pushes would exceed depth, drop the newest words (design-error case; no flag).
//  - Changes to rle_mode/disabledGroups while active take effect immediately;
//    software changes them only while !enable.
//  - Reset mid-run: all state is cleared; pending count and FIFO words are discarded.
// STRUCTURE
//  - Package rle_pkg:
//      group-mask-to-width decode function, flag-position function,
//      word-kind constants (VALUE/COUNT), run-state enum {IDLE, RUN}.
//  - Sub-module rle_out_fifo: 4-entry, dual-push/single-pop, registered output.
//  - Top: encode FSM + counter + width masking.
// TESTING
//  1. Bypass: enable=0, 256 samples {4{i[7:0]}}, i=0..255
//     -> identical 256 words in order; first word 1 cycle after first push.
//  2. 8-bit (1110), enable=arm=1, samples 41,42,43,43,43,44
//     -> 00000041, 00000042, 00000043, 00000082, 00000044.
//  3. Saturation, 8-bit, mode 0: 0x47 x130, then 0x48
//     -> 47, FF (127), 82, 48.
//     Same stimulus with mode 1 -> 47, FF, 47, 82, 48.
//  4. 32-bit (0000): 0x12345678 x3, then 0x00000001
//     -> 12345678, 80000002, 00000001.
//  5. Disarm mid-run: 8-bit 0x55 x5, then arm=0 with sample 0x66
//     -> 55, 84, then bypass word 00000066.
//  6. Reset mid-run (rst=1 while count=3)
//     -> sto_valid=0 the next cycle; after release the first sample is a VALUE word.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: width decode, word building
// and the small constants used by the encoder FSM and its output FIFO.
package rle_pkg;

  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic KIND_VALUE = 1'b0;
  localparam logic KIND_COUNT = 1'b1;

  function automatic logic [5:0] width_from_groups(input logic [3:0] groups);
    case (groups)
      4'b1110: return 6'd8;
      4'b1100: return 6'd16;
      4'b1000: return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [4:0] flag_pos(input logic [3:0] groups);
    logic [5:0] f;
    f = width_from_groups(groups) - 6'd1;
    return f[4:0];
  endfunction

  // Low W-1 bits carry the payload; bit W-1 marks a repeat count.
  function automatic logic [WORD_W-1:0] make_word(input logic kind,
                                                  input logic [WORD_W-1:0] payload,
                                                  input logic [4:0] fpos);
    logic [WORD_W-1:0] flagBit;
    flagBit = WORD_W'(1) << fpos;
    return (payload & (flagBit - WORD_W'(1))) | (kind ? flagBit : '0);
  endfunction

endpackage

// File: rtl/rle_out_fifo.sv
// Small output queue: accepts up to two words per cycle in order and presents
// at most one per cycle on a registered output port.
module rle_out_fifo
  import rle_pkg::*;
#(
  parameter int DW    = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push0_valid_i,
  input  logic [DW-1:0] push0_data_i,
  input  logic          push1_valid_i,
  input  logic [DW-1:0] push1_data_i,
  output logic [DW-1:0] pop_data_o,
  output logic          pop_valid_o
);

  localparam int SLOTS = DEPTH + 2;
  localparam int CW    = $clog2(SLOTS + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] fill_q, fill_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] slots [SLOTS];
  logic [CW-1:0] total;
  logic [CW-1:0] remain;

  // Stored words followed by this cycle's pushes form one ordered list; the
  // head goes to the output register and the tail, clipped to DEPTH, is kept.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) slots[i] = '0;
    for (int i = 0; i < DEPTH; i++) slots[i] = mem_q[i];
    total = fill_q;
    if (push0_valid_i) begin
      slots[total] = push0_data_i;
      total        = total + CW'(1);
    end
    if (push1_valid_i) begin
      slots[total] = push1_data_i;
      total        = total + CW'(1);
    end
    remain  = (total == '0) ? '0 : total - CW'(1);
    fill_d  = (remain > CW'(DEPTH)) ? CW'(DEPTH) : remain;
    valid_d = (total != '0);
    data_d  = (total != '0) ? slots[0] : data_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = slots[i+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign pop_data_o  = data_q;
  assign pop_valid_o = valid_q;

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder between the sample path and capture memory: bypass when
// not armed, otherwise one VALUE word per new value plus flagged COUNT words.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int DW = WORD_W,
  parameter int KW = DW / 8
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          arm,
  input  logic [1:0]    rle_mode,
  input  logic [KW-1:0] disabledGroups,
  input  logic [DW-1:0] sti_data,
  input  logic          sti_valid,
  output logic [DW-1:0] sto_data,
  output logic          sto_valid
);

  logic          active;
  logic [4:0]    flagPos;
  logic [DW-1:0] valueMask;
  logic [DW-1:0] sampleValue;
  logic [DW-2:0] maxCount;
  logic [DW-2:0] countInc;
  logic [DW-1:0] valueWord, lastWord, countWord, maxWord;
  logic [0:0]    state_q, state_d;
  logic [DW-2:0] count_q, count_d;
  logic [DW-1:0] last_q, last_d;
  logic          p0Valid, p1Valid;
  logic [DW-1:0] p0Data, p1Data;
  logic          unused_mode;

  assign active      = enable && arm;
  assign flagPos     = flag_pos(disabledGroups);
  assign valueMask   = (DW'(1) << flagPos) - DW'(1);
  assign sampleValue = sti_data & valueMask;
  assign maxCount    = valueMask[DW-2:0];
  assign countInc    = count_q + (DW-1)'(1);
  assign valueWord   = make_word(KIND_VALUE, sti_data, flagPos);
  assign lastWord    = make_word(KIND_VALUE, last_q, flagPos);
  assign countWord   = make_word(KIND_COUNT, {1'b0, count_q}, flagPos);
  assign maxWord     = make_word(KIND_COUNT, {1'b0, maxCount}, flagPos);
  assign unused_mode = rle_mode[1];

  // Encode step: decides up to two words for this cycle, COUNT before VALUE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    p0Valid = 1'b0;
    p0Data  = '0;
    p1Valid = 1'b0;
    p1Data  = '0;
    if (!active) begin
      if (state_q == ST_RUN && count_q != '0) begin
        p0Valid = 1'b1;
        p0Data  = countWord;
      end
      if (sti_valid) begin
        if (p0Valid) begin
          p1Valid = 1'b1;
          p1Data  = sti_data;
        end else begin
          p0Valid = 1'b1;
          p0Data  = sti_data;
        end
      end
      state_d = ST_IDLE;
      count_d = '0;
    end else if (sti_valid) begin
      if (state_q == ST_IDLE) begin
        p0Valid = 1'b1;
        p0Data  = valueWord;
        last_d  = sampleValue;
        count_d = '0;
        state_d = ST_RUN;
      end else if (sampleValue == (last_q & valueMask)) begin
        // >= keeps the counter bounded even if the width shrank mid-run.
        if (countInc >= maxCount) begin
          p0Valid = 1'b1;
          p0Data  = maxWord;
          count_d = '0;
          if (rle_mode[0]) begin
            p1Valid = 1'b1;
            p1Data  = lastWord;
          end
        end else begin
          count_d = countInc;
        end
      end else begin
        if (count_q != '0) begin
          p0Valid = 1'b1;
          p0Data  = countWord;
          p1Valid = 1'b1;
          p1Data  = valueWord;
        end else begin
          p0Valid = 1'b1;
          p0Data  = valueWord;
        end
        last_d  = sampleValue;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  rle_out_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push0_valid_i (p0Valid),
    .push0_data_i  (p0Data),
    .push1_valid_i (p1Valid),
    .push1_data_i  (p1Data),
    .pop_data_o    (sto_data),
    .pop_valid_o   (sto_valid)
  );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: captures every output word and compares the
// stream of each scenario against hand-computed expected words.
module tb_rle_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        arm;
  logic [1:0]  rle_mode;
  logic [3:0]  disabledGroups;
  logic [31:0] sti_data;
  logic        sti_valid;
  logic [31:0] sto_data;
  logic        sto_valid;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          firstCyc;
  logic [31:0] got[$];
  int          gotCyc[$];
  logic [31:0] expQ[$];

  rle_encoder #(.DW(32), .KW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .arm            (arm),
    .rle_mode       (rle_mode),
    .disabledGroups (disabledGroups),
    .sti_data       (sti_data),
    .sti_valid      (sti_valid),
    .sto_data       (sto_data),
    .sto_valid      (sto_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sto_valid === 1'b1) begin
      got.push_back(sto_data);
      gotCyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [31:0] d, input logic v);
    @(negedge clk);
    sti_data  = d;
    sti_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(32'h0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkStream(input string tag);
    logic [31:0] obs;
    vectors++;
    assert (got.size() === expQ.size()) else begin
      miscompares++;
      $error("[TB] FAIL %s_len observed=%0d expected=%0d", tag, got.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      checkOutput($sformatf("%s[%0d]", tag, i), obs, expQ[i]);
    end
  endtask

  task automatic startTest(input logic [3:0] groups, input logic [1:0] mode);
    enable = 1'b0;
    idle(2);
    disabledGroups = groups;
    rle_mode       = mode;
    got.delete();
    gotCyc.delete();
    enable = 1'b1;
    arm    = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    arm            = 1'b0;
    rle_mode       = 2'b00;
    disabledGroups = 4'b0000;
    sti_data       = '0;
    sti_valid      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {31'b0, sto_valid}, 32'h0);
    checkOutput("reset_data", sto_data, 32'h0);
    rst = 1'b0;
    idle(1);

    // Bypass: 256 replicated-byte samples, one word per cycle, 1-cycle latency.
    got.delete();
    gotCyc.delete();
    expQ.delete();
    firstCyc = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      applyStimulus({4{b}}, 1'b1);
      if (i == 0) firstCyc = cyc;
      expQ.push_back({4{b}});
    end
    idle(4);
    checkStream("bypass");
    checkOutput("bypass_latency", (gotCyc.size() > 0) ? gotCyc[0] : -1, firstCyc + 1);

    // 8-bit basic runs.
    startTest(4'b1110, 2'b00);
    applyStimulus(32'h41, 1'b1);
    applyStimulus(32'h42, 1'b1);
    applyStimulus(32'h43, 1'b1);
    applyStimulus(32'h43, 1'b1);
    applyStimulus(32'h43, 1'b1);
    applyStimulus(32'h44, 1'b1);
    idle(4);
    expQ = '{32'h41, 32'h42, 32'h43, 32'h82, 32'h44};
    checkStream("w8_basic");
    checkOutput("hold_valid", {31'b0, sto_valid}, 32'h0);
    checkOutput("hold_data", sto_data, 32'h44);

    // Saturation, mode 0 (reserved bit 1 set, must be ignored).
    startTest(4'b1110, 2'b10);
    repeat (130) applyStimulus(32'h47, 1'b1);
    applyStimulus(32'h48, 1'b1);
    idle(4);
    expQ = '{32'h47, 32'hFF, 32'h82, 32'h48};
    checkStream("sat_mode0");

    // Saturation, mode 1 re-emits the value after the saturated count.
    startTest(4'b1110, 2'b01);
    repeat (130) applyStimulus(32'h47, 1'b1);
    applyStimulus(32'h48, 1'b1);
    idle(4);
    expQ = '{32'h47, 32'hFF, 32'h47, 32'h82, 32'h48};
    checkStream("sat_mode1");

    // 32-bit width.
    startTest(4'b0000, 2'b00);
    repeat (3) applyStimulus(32'h12345678, 1'b1);
    applyStimulus(32'h00000001, 1'b1);
    idle(4);
    expQ = '{32'h12345678, 32'h80000002, 32'h00000001};
    checkStream("w32");

    // 16-bit: only bits [14:0] compare and appear in the VALUE word.
    startTest(4'b1100, 2'b00);
    applyStimulus(32'hFFFF1234, 1'b1);
    applyStimulus(32'h00001234, 1'b1);
    applyStimulus(32'h00009234, 1'b1);
    applyStimulus(32'h00001235, 1'b1);
    idle(4);
    expQ = '{32'h00001234, 32'h00008002, 32'h00001235};
    checkStream("w16");

    // 24-bit.
    startTest(4'b1000, 2'b00);
    repeat (2) applyStimulus(32'h12ABCDEF, 1'b1);
    applyStimulus(32'h00000001, 1'b1);
    idle(4);
    expQ = '{32'h002BCDEF, 32'h00800001, 32'h00000001};
    checkStream("w24");

    // Disarm mid-run: pending count flushed before the bypass sample.
    startTest(4'b1110, 2'b00);
    repeat (5) applyStimulus(32'h55, 1'b1);
    applyStimulus(32'h66, 1'b1);
    arm = 1'b0;
    idle(4);
    expQ = '{32'h55, 32'h84, 32'h66};
    checkStream("disarm");

    // Reset mid-run discards the pending count of 3.
    startTest(4'b1110, 2'b00);
    repeat (4) applyStimulus(32'h55, 1'b1);
    @(negedge clk);
    sti_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", {31'b0, sto_valid}, 32'h0);
    rst = 1'b0;
    applyStimulus(32'h55, 1'b1);
    applyStimulus(32'h56, 1'b1);
    idle(4);
    expQ = '{32'h55, 32'h55, 32'h56};
    checkStream("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
